// File: rtl/down_counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and default data width.
package counter_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StExpire = 2'd2
  } state_e;

endpackage

// File: rtl/down_counter_if.sv
// Load/enable inputs and count/status outputs of down_counter bundled as one interface.
interface down_counter_if #(
  parameter int unsigned WIDTH = counter_pkg::DefaultWidth
) ();

  logic [WIDTH-1:0] d_in;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] c_out;
  logic             tc;
  logic             busy;

  modport master (
    output d_in,
    output load,
    output en,
    input  c_out,
    input  tc,
    input  busy
  );

  modport slave (
    input  d_in,
    input  load,
    input  en,
    output c_out,
    output tc,
    output busy
  );

endinterface

// File: rtl/down_counter.sv
// Loadable, enabled down counter with registered one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the last loaded value after each expiry.
module down_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic          clk,
  input  logic          rst,
  down_counter_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    busy_d   = busy_q;

    if (bus.load) begin
      count_d  = bus.d_in;
      reload_d = bus.d_in;
      if (bus.d_in != '0) begin
        state_d = StRun;
        busy_d  = 1'b1;
      end else begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.en) begin
            // Decrement only from >= 1, so the count can never wrap.
            if (count_q <= WIDTH'(1)) begin
              count_d = '0;
              state_d = StExpire;
              tc_d    = 1'b1;
              busy_d  = 1'b0;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        StExpire: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          count_d = reload_q;
          state_d = StRun;
          busy_d  = 1'b1;
`else
          state_d = StIdle;
          busy_d  = 1'b0;
`endif
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.c_out = count_q;
  assign bus.tc    = tc_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed-step bench for down_counter; expected outputs queued per step and checked after the edge.
module tb_down_counter;

  localparam int unsigned W = 4;

  typedef struct {
    string        tag;
    logic [W-1:0] c;
    logic         tc;
    logic         busy;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  down_counter_if #(.WIDTH(W)) bus ();

  down_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on run time in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input string tag, input logic r, input logic ld, input logic [W-1:0] d,
                      input logic e, input logic [W-1:0] exp_c, input logic exp_tc,
                      input logic exp_busy);
    exp_t x;
    @(negedge clk);
    rst      = r;
    bus.load = ld;
    bus.d_in = d;
    bus.en   = e;
    x.tag    = tag;
    x.c      = exp_c;
    x.tc     = exp_tc;
    x.busy   = exp_busy;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert (bus.c_out === x.c) else begin
      errors++;
      $error("FAIL %s c_out: got %0d expected %0d", x.tag, bus.c_out, x.c);
    end
    checks++;
    assert (bus.tc === x.tc) else begin
      errors++;
      $error("FAIL %s tc: got %b expected %b", x.tag, bus.tc, x.tc);
    end
    checks++;
    assert (bus.busy === x.busy) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", x.tag, bus.busy, x.busy);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.d_in = '0;
    bus.en   = 1'b0;

    // Reset, then reset mid-count, then reset overriding load.
    step("rst0",      1, 0, 0, 0, 0, 0, 0);
    step("rst1",      1, 0, 0, 1, 0, 0, 0);
    step("ld5",       0, 1, 5, 0, 5, 0, 1);
    step("hold5",     0, 0, 0, 0, 5, 0, 1);
    step("rst_mid",   1, 0, 0, 1, 0, 0, 0);
    step("rst_ld",    1, 1, 7, 1, 0, 0, 0);
    step("idle_en",   0, 0, 0, 1, 0, 0, 0);

    // Load 6 and count to expiry.
    step("ld6",       0, 1, 6, 1, 6, 0, 1);
    for (int v = 5; v >= 1; v--) step("cnt6", 0, 0, 0, 1, W'(v), 0, 1);
    step("tc6",       0, 0, 0, 1, 0, 1, 0);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    step("rl6",       0, 0, 0, 1, 6, 0, 1);
`else
    step("post6a",    0, 0, 0, 1, 0, 0, 0);
    step("post6b",    0, 0, 0, 1, 0, 0, 0);
`endif

    // Load 14, pause 3 cycles at 9: tc arrives 17 edges after load.
    step("ld14",      0, 1, 14, 1, 14, 0, 1);
    for (int v = 13; v >= 9; v--) step("cnt14", 0, 0, 0, 1, W'(v), 0, 1);
    for (int i = 0; i < 3; i++) step("pause9", 0, 0, 0, 0, 9, 0, 1);
    for (int v = 8; v >= 1; v--) step("cnt14b", 0, 0, 0, 1, W'(v), 0, 1);
    step("tc14",      0, 0, 0, 1, 0, 1, 0);

    // Load 0: no run, no pulse.
    step("ld0",       0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("zero", 0, 0, 0, 1, 0, 0, 0);

    // Reload during RUN at 3 with 2: only one tc in total.
    step("ld6b",      0, 1, 6, 1, 6, 0, 1);
    for (int v = 5; v >= 3; v--) step("cnt6b", 0, 0, 0, 1, W'(v), 0, 1);
    step("rld2",      0, 1, 2, 1, 2, 0, 1);
    step("cnt2",      0, 0, 0, 1, 1, 0, 1);
    step("tc2",       0, 0, 0, 1, 0, 1, 0);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    step("post2",     0, 0, 0, 1, 0, 0, 0);
`endif

    // Load 1 expires next edge; load in EXPIRE restarts and drops tc.
    step("ld1",       0, 1, 1, 1, 1, 0, 1);
    step("tc1",       0, 0, 0, 1, 0, 1, 0);
    step("ld_exp",    0, 1, 3, 1, 3, 0, 1);
    step("cnt3",      0, 0, 0, 1, 2, 0, 1);
    step("paused3",   0, 0, 0, 0, 2, 0, 1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Free-running period D+1 with en held high.
    step("ar_ld3",    0, 1, 3, 1, 3, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("ar2",     0, 0, 0, 1, 2, 0, 1);
      step("ar1",     0, 0, 0, 1, 1, 0, 1);
      step("ar0",     0, 0, 0, 1, 0, 1, 0);
      step("ar3",     0, 0, 0, 1, 3, 0, 1);
    end
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
